// File: rtl/jtopl_chreg_if.sv
// Host write bus into the channel-register block.
// Kind-0 latch writes do not use wr_ready; kinds 1 and 2 wait for the one-entry buffer.
interface jtopl_chreg_if #(
  parameter int unsigned CHW = 5
);
  logic           wr_valid;
  logic           wr_ready;
  logic [CHW-1:0] wr_ch;
  logic [1:0]     wr_kind;
  logic [7:0]     wr_data;

  modport master (
    output wr_valid,
    output wr_ch,
    output wr_kind,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_ch,
    input  wr_kind,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/jtopl_chreg.sv
// Slot sequencer plus per-channel config store for OPL2/OPL3 channels.
// Host writes sit in a one-entry buffer until the target channel's modulator slot comes up.
module jtopl_chreg #(
  parameter int unsigned CH  = 18,
  parameter int unsigned CHW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen_i,
  jtopl_chreg_if.slave    wr,
  output logic            zero_o,
  output logic [CHW-1:0]  ch_o,
  output logic            op_o,
  output logic [9:0]      fnum_o,
  output logic [2:0]      block_o,
  output logic            keyon_o,
  output logic [2:0]      fb_o,
  output logic            con_o
);

  localparam int unsigned Slots = 2 * CH;
  localparam int unsigned SW    = $clog2(Slots);

  logic [SW-1:0]  slot_q, slot_nx;
  logic [31:0]    s_nx;
  logic [CHW-1:0] ch_nx;
  logic           op_nx;

  logic           zero_q, op_q;
  logic [CHW-1:0] ch_q;
  logic [9:0]     fnum_q;
  logic [2:0]     block_q, fb_q;
  logic           keyon_q, con_q;

  logic [7:0]     latch_q;
  logic           pend_q;
  logic           pend_k2_q;
  logic [CHW-1:0] pend_ch_q;
  logic [13:0]    pend_data_q;

  logic [9:0]     fnum_st  [CH];
  logic [2:0]     block_st [CH];
  logic           keyon_st [CH];
  logic [2:0]     fb_st    [CH];
  logic           con_st   [CH];

  logic ch_ok, latch_we, buf_we, commit;

  assign slot_nx = (slot_q == SW'(Slots - 1)) ? '0 : slot_q + 1'b1;
  assign s_nx    = 32'(slot_nx);
  // Groups of six slots: three modulators then three carriers of channels 3g..3g+2.
  assign ch_nx   = CHW'(3 * (s_nx / 6) + (s_nx % 6) % 3);
  assign op_nx   = (s_nx % 6) >= 3;

  assign ch_ok    = 32'(wr.wr_ch) < CH;
  assign wr.wr_ready = ~pend_q;
  // The fnum latch needs no buffer, so it is taken even while a write is pending.
  assign latch_we = wr.wr_valid && ch_ok && (wr.wr_kind == 2'd0);
  assign buf_we   = wr.wr_valid && wr.wr_ready && ch_ok &&
                    ((wr.wr_kind == 2'd1) || (wr.wr_kind == 2'd2));
  assign commit   = cen_i && pend_q && !op_nx && (ch_nx == pend_ch_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q     <= '0;
      pend_q      <= 1'b0;
      pend_k2_q   <= 1'b0;
      pend_ch_q   <= '0;
      pend_data_q <= '0;
    end else begin
      if (latch_we) latch_q <= wr.wr_data;
      if (commit) begin
        pend_q <= 1'b0;
      end else if (buf_we) begin
        pend_q    <= 1'b1;
        pend_k2_q <= wr.wr_kind[1];
        pend_ch_q <= wr.wr_ch;
        pend_data_q <= wr.wr_kind[1] ? {10'd0, wr.wr_data[3:0]}
                                     : {wr.wr_data[5:0], latch_q};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CH); i++) begin
        fnum_st[i]  <= '0;
        block_st[i] <= '0;
        keyon_st[i] <= 1'b0;
        fb_st[i]    <= '0;
        con_st[i]   <= 1'b0;
      end
    end else if (commit) begin
      if (pend_k2_q) begin
        fb_st[pend_ch_q]  <= pend_data_q[3:1];
        con_st[pend_ch_q] <= pend_data_q[0];
      end else begin
        keyon_st[pend_ch_q] <= pend_data_q[13];
        block_st[pend_ch_q] <= pend_data_q[12:10];
        fnum_st[pend_ch_q]  <= pend_data_q[9:0];
      end
    end
  end

  // Outputs look up the upcoming channel; a commit to it bypasses the store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      zero_q  <= 1'b1;
      ch_q    <= '0;
      op_q    <= 1'b0;
      fnum_q  <= '0;
      block_q <= '0;
      keyon_q <= 1'b0;
      fb_q    <= '0;
      con_q   <= 1'b0;
    end else if (cen_i) begin
      slot_q  <= slot_nx;
      zero_q  <= (slot_nx == '0);
      ch_q    <= ch_nx;
      op_q    <= op_nx;
      fnum_q  <= (commit && !pend_k2_q) ? pend_data_q[9:0]   : fnum_st[ch_nx];
      block_q <= (commit && !pend_k2_q) ? pend_data_q[12:10] : block_st[ch_nx];
      keyon_q <= (commit && !pend_k2_q) ? pend_data_q[13]    : keyon_st[ch_nx];
      fb_q    <= (commit && pend_k2_q)  ? pend_data_q[3:1]   : fb_st[ch_nx];
      con_q   <= (commit && pend_k2_q)  ? pend_data_q[0]     : con_st[ch_nx];
    end
  end

  assign zero_o  = zero_q;
  assign ch_o    = ch_q;
  assign op_o    = op_q;
  assign fnum_o  = fnum_q;
  assign block_o = block_q;
  assign keyon_o = keyon_q;
  assign fb_o    = fb_q;
  assign con_o   = con_q;

endmodule
